// File: rtl/block_lock_ctrl.sv
// block_lock_ctrl: 66b block-alignment acquisition, verification and lock monitoring.
module block_lock_ctrl #(
  parameter int STABLE_CNT = 8,
  parameter int SETTLE_BLK = 2,
  parameter int LOCK_CNT   = 32,
  parameter int WIN_BLK    = 64,
  parameter int ERR_MAX    = 16,
  parameter int OFFSET_MAX = 66
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       hdr_dv_i,
  input  logic       hdr_ok_i,
  input  logic [6:0] seek_offset_i,
  output logic [6:0] offset_o,
  output logic       offset_load_o,
  output logic       locked_o,
  output logic [1:0] state_o,
  output logic [7:0] lock_loss_cnt_o
);
  localparam int W = $clog2(WIN_BLK + 1);
  localparam logic [7:0] STABLE_V = 8'(STABLE_CNT);
  localparam logic [7:0] LOCK_V = 8'(LOCK_CNT);
  localparam logic [3:0] SETTLE_V = 4'(SETTLE_BLK);
  localparam logic [6:0] OFF_MAX_V = 7'(OFFSET_MAX);
  localparam logic [W-1:0] WIN_LAST_V = W'(WIN_BLK - 1);
  localparam logic [W-1:0] ERR_MAX_V = W'(ERR_MAX);
  typedef enum logic [1:0] {SEARCH = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;
  state_t state_q, state_d;
  logic [6:0] offset_q, offset_d, prev_q, prev_d;
  logic load_q, load_d, locked_q, locked_d;
  logic [7:0] loss_q, loss_d, stable_q, stable_d, good_q, good_d, stable_nx;
  logic [3:0] settle_q, settle_d;
  logic [W-1:0] blk_q, blk_d, err_q, err_d, err_nx;
  logic settled, good, bad;
  assign settled = settle_q == 4'd0;
  assign good = settled && hdr_ok_i;
  assign bad = settled && !hdr_ok_i;
  assign stable_nx = (seek_offset_i > OFF_MAX_V) ? 8'd0 :
                     (seek_offset_i != prev_q) ? 8'd1 :
                     (stable_q == 8'hFF) ? stable_q : stable_q + 8'd1;
  assign err_nx = err_q + {{(W-1){1'b0}}, bad};
  always_comb begin
    state_d = state_q;
    offset_d = offset_q;
    prev_d = prev_q;
    load_d = 1'b0;
    locked_d = locked_q;
    loss_d = loss_q;
    stable_d = stable_q;
    good_d = good_q;
    settle_d = (hdr_dv_i && !settled) ? settle_q - 4'd1 : settle_q;
    blk_d = blk_q;
    err_d = err_q;
    if (hdr_dv_i) begin
      unique case (state_q)
        SEARCH: begin
          prev_d = seek_offset_i;
          stable_d = stable_nx;
          if (stable_nx == STABLE_V) begin
            offset_d = seek_offset_i;
            load_d = 1'b1;
            good_d = 8'd0;
            stable_d = 8'd0;
            settle_d = SETTLE_V;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (good) begin
            good_d = good_q + 8'd1;
            if (good_q + 8'd1 == LOCK_V) begin
              state_d = LOCKED;
              locked_d = 1'b1;
              blk_d = '0;
              err_d = '0;
            end
          end else if (bad) begin
            state_d = SEARCH;
            stable_d = 8'd0;
          end
        end
        LOCKED: begin
          blk_d = blk_q + {{(W-1){1'b0}}, 1'b1};
          err_d = err_nx;
          // A loss on the last block of a window wins over the window clear
          if (err_nx == ERR_MAX_V) begin
            state_d = SEARCH;
            locked_d = 1'b0;
            loss_d = loss_q + {7'd0, loss_q != 8'hFF};
            stable_d = 8'd0;
          end else if (blk_q == WIN_LAST_V) begin
            blk_d = '0;
            err_d = '0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SEARCH;
      offset_q <= 7'd0;
      prev_q <= 7'h7F;
      load_q <= 1'b0;
      locked_q <= 1'b0;
      loss_q <= 8'd0;
      stable_q <= 8'd0;
      good_q <= 8'd0;
      settle_q <= 4'd0;
      blk_q <= '0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      offset_q <= offset_d;
      prev_q <= prev_d;
      load_q <= load_d;
      locked_q <= locked_d;
      loss_q <= loss_d;
      stable_q <= stable_d;
      good_q <= good_d;
      settle_q <= settle_d;
      blk_q <= blk_d;
      err_q <= err_d;
    end
  end
  assign offset_o = offset_q;
  assign offset_load_o = load_q;
  assign locked_o = locked_q;
  assign state_o = state_q;
  assign lock_loss_cnt_o = loss_q;
endmodule

// File: tb/tb_block_lock_ctrl.sv
// tb_block_lock_ctrl: scoreboarded random/directed bench for block_lock_ctrl with a behavioural reference model.
module tb_block_lock_ctrl;
  logic clk = 1'b0;
  logic rst_i = 1'b1, hdr_dv_i = 1'b0, hdr_ok_i = 1'b0;
  logic [6:0] seek_offset_i = 7'd0;
  logic [6:0] offset_o;
  logic offset_load_o, locked_o;
  logic [1:0] state_o;
  logic [7:0] lock_loss_cnt_o;
  block_lock_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .hdr_dv_i(hdr_dv_i), .hdr_ok_i(hdr_ok_i),
    .seek_offset_i(seek_offset_i), .offset_o(offset_o), .offset_load_o(offset_load_o),
    .locked_o(locked_o), .state_o(state_o), .lock_loss_cnt_o(lock_loss_cnt_o)
  );
  always #5 clk = ~clk;
  typedef struct {int off; bit ld; bit lk; int st; int loss; int idx;} exp_t;
  exp_t expq[$];
  int n_chk = 0, n_fail = 0, idx = 0, load_at = -1, lock_at = -1;
  int m_state = 0, m_off = 0, m_prev = 127, m_stable = 0, m_good = 0, m_settle = 0;
  int m_blk = 0, m_err = 0, m_loss = 0;
  bit m_load = 0, m_lock = 0;
  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Reference: what the outputs must be after one clock with the given inputs
  task automatic model(bit r, bit dv, bit ok, int seek);
    bit ign;
    m_load = 0;
    if (r) begin
      m_state = 0; m_off = 0; m_lock = 0; m_loss = 0; m_stable = 0;
      m_good = 0; m_settle = 0; m_blk = 0; m_err = 0; m_prev = 127;
    end else if (dv) begin
      ign = m_settle != 0;
      if (ign) m_settle--;
      if (m_state == 0) begin
        if (seek > 66) m_stable = 0;
        else if (seek == m_prev) m_stable = (m_stable < 255) ? m_stable + 1 : 255;
        else m_stable = 1;
        m_prev = seek;
        if (m_stable == 8) begin
          m_off = seek; m_load = 1; m_good = 0; m_stable = 0; m_settle = 2; m_state = 1;
        end
      end else if (m_state == 1) begin
        if (!ign && ok) begin
          m_good++;
          if (m_good == 32) begin m_state = 2; m_lock = 1; m_blk = 0; m_err = 0; end
        end else if (!ign) begin
          m_state = 0; m_stable = 0;
        end
      end else begin
        if (!ign && !ok) m_err++;
        if (m_err == 16) begin
          m_state = 0; m_lock = 0; m_stable = 0;
          if (m_loss < 255) m_loss++;
        end else if (m_blk == 63) begin
          m_blk = 0; m_err = 0;
        end else m_blk++;
      end
    end
  endtask
  task automatic step(bit r, bit dv, bit ok, int seek);
    exp_t e;
    @(negedge clk);
    rst_i = r; hdr_dv_i = dv; hdr_ok_i = ok; seek_offset_i = 7'(seek);
    if (dv && !r) idx++;
    model(r, dv, ok, seek);
    e.off = m_off; e.ld = m_load; e.lk = m_lock; e.st = m_state; e.loss = m_loss; e.idx = idx;
    expq.push_back(e);
  endtask
  task automatic dv_step(bit ok, int seek);
    if ($urandom_range(0, 3) == 0) step(0, 0, 1'($urandom_range(0, 1)), $urandom_range(0, 127));
    step(0, 1, ok, seek);
  endtask
  task automatic sync();
    step(0, 0, 0, 0);
    @(posedge clk);
    #2;
  endtask
  task automatic restart();
    step(1, 0, 0, 0);
    step(1, 1, 1, 37);
    sync();
    idx = 0; load_at = -1; lock_at = -1;
  endtask
  task automatic acquire();
    repeat (42) dv_step(1, 37);
  endtask
  task automatic window(int nerr, bit at_end, bit trunc);
    bit errs[64];
    int n, p, last;
    for (int k = 0; k < 64; k++) errs[k] = 0;
    n = 0;
    while (n < nerr) begin
      p = $urandom_range(0, 62);
      if (!errs[p]) begin errs[p] = 1; n++; end
    end
    if (at_end) errs[63] = 1;
    last = 63;
    if (trunc) begin
      last = 0;
      for (int k = 0; k < 64; k++) if (errs[k]) last = k;
    end
    for (int k = 0; k <= last; k++) dv_step(!errs[k], 37);
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("offset_o", int'(offset_o), e.off);
        chk("offset_load_o", int'(offset_load_o), int'(e.ld));
        chk("locked_o", int'(locked_o), int'(e.lk));
        chk("state_o", int'(state_o), e.st);
        chk("lock_loss_cnt_o", int'(lock_loss_cnt_o), e.loss);
        if (offset_load_o && load_at < 0) load_at = e.idx;
        if (locked_o && lock_at < 0) lock_at = e.idx;
      end
    end
  end
  initial begin : stim
    bit r;
    int s;
    restart();
    chk("reset_locked", int'(locked_o), 0);
    repeat (50) dv_step(1, 37);
    sync();
    chk("clean_load_dv", load_at, 8);
    chk("clean_lock_dv", lock_at, 42);
    chk("clean_offset", int'(offset_o), 37);
    chk("clean_state", int'(state_o), 2);
    restart();
    for (int i = 0; i < 20; i++) dv_step(1, (i % 2 == 0) ? 10 : 11);
    repeat (10) dv_step(1, 11);
    sync();
    chk("unstable_load_dv", load_at, 27);
    chk("unstable_offset", int'(offset_o), 11);
    restart();
    repeat (20) dv_step(1, 70);
    sync();
    chk("oor_no_load", load_at, -1);
    chk("oor_state", int'(state_o), 0);
    repeat (8) dv_step(1, 5);
    sync();
    chk("oor_then_load_dv", load_at, 28);
    dv_step(0, 9);
    dv_step(0, 9);
    repeat (5) dv_step(1, 9);
    sync();
    chk("verify_settle_ignored", int'(state_o), 1);
    dv_step(0, 9);
    sync();
    chk("verify_fail_state", int'(state_o), 0);
    chk("verify_fail_offset", int'(offset_o), 5);
    chk("verify_fail_loss", int'(lock_loss_cnt_o), 0);
    restart();
    acquire();
    window(15, 0, 0);
    window(15, 0, 0);
    sync();
    chk("two_windows_locked", int'(locked_o), 1);
    window(16, 0, 1);
    sync();
    chk("loss16_locked", int'(locked_o), 0);
    chk("loss16_cnt", int'(lock_loss_cnt_o), 1);
    acquire();
    window(15, 1, 1);
    sync();
    chk("loss_blk63_state", int'(state_o), 0);
    chk("loss_blk63_cnt", int'(lock_loss_cnt_o), 2);
    for (int i = 0; i < 300; i++) begin
      acquire();
      repeat (16) dv_step(0, 37);
    end
    sync();
    chk("loss_saturated", int'(lock_loss_cnt_o), 255);
    acquire();
    sync();
    chk("pre_reset_locked", int'(locked_o), 1);
    load_at = -1;
    step(1, 1, 1, 37);
    @(posedge clk);
    #2;
    chk("rst_state", int'(state_o), 0);
    chk("rst_locked", int'(locked_o), 0);
    chk("rst_loss", int'(lock_loss_cnt_o), 0);
    chk("rst_offset", int'(offset_o), 0);
    step(0, 1, 1, 37);
    step(0, 1, 1, 37);
    sync();
    chk("no_load_after_reset", load_at, -1);
    restart();
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 499) == 0;
      s = $urandom_range(0, 19);
      s = (s < 17) ? 20 : (s < 19) ? 21 : 90;
      step(r, $urandom_range(0, 3) != 0, $urandom_range(0, 15) != 0, s);
    end
    sync();
    chk("queue_drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/block_lock_ctrl.md
# block_lock_ctrl

Block-alignment controller for the 66b receive path. Consumes the header seeker's candidate offset and a per-block header-check result at the applied offset. Decides when to adopt a candidate, verifies it, declares lock and drops lock on excessive header errors. Drives the offset used by the downstream block extractor and reports lock status to the channel status logic.

## Interface

Parameters:

- STABLE_CNT, 8: consecutive identical in-range seeker samples required before adopting a candidate (2..255)
- SETTLE_BLK, 2: blocks ignored after each offset load, covering extractor latency (0..15)
- LOCK_CNT, 32: consecutive good headers in VERIFY needed to lock (1..255)
- WIN_BLK, 64: LOCKED error-monitor window length in blocks (2..1024)
- ERR_MAX, 16: bad headers within one window that cause lock loss (1..WIN_BLK)
- OFFSET_MAX, 66: largest legal offset value

Ports (`clk_i` first, then `rst_i`, then the rest):

- clk_i  in  1  system clock; one clock, all logic on rising edge
- rst_i  in  1  reset; synchronous, active-high
- hdr_dv_i  in  1  one-cycle strobe per received 66b block; qualifies all inputs below
- hdr_ok_i  in  1  header at current offset_o is 2'b01 or 2'b10
- seek_offset_i  in  7  seeker's current best offset
- offset_o  out  7  applied block offset
- offset_load_o  out  1  one-cycle pulse, coincident with an offset_o change
- locked_o  out  1  block lock achieved
- state_o  out  2  SEARCH=0, VERIFY=1, LOCKED=2; 3 is unused
- lock_loss_cnt_o  out  8  number of LOCKED→SEARCH transitions, saturates at 255

## Operation

- All outputs are registered.
- All counters advance only on cycles with hdr_dv_i=1. Inputs are ignored when hdr_dv_i=0.
- Settle counter:
  - Loaded with SETTLE_BLK on every offset_load_o.
  - While it is nonzero, each hdr_dv_i decrements it and hdr_ok_i is ignored in every state.

SEARCH:
- Tracks the previously sampled seek_offset_i.
- Stable counter update on each hdr_dv_i:
  - seek_offset_i > OFFSET_MAX: stable_cnt=0.
  - seek_offset_i equals the previous sample: stable_cnt+1, saturating.
  - Otherwise: stable_cnt=1.
- When stable_cnt reaches STABLE_CNT:
  - offset_o ← seek_offset_i and offset_load_o=1.
  - good_cnt=0, stable_cnt=0.
  - Go to VERIFY.
- If the new offset equals the current offset_o, offset_load_o still pulses.

VERIFY:
- Unsettled hdr_ok_i=1: good_cnt+1. Reaching LOCK_CNT goes to LOCKED, sets locked_o=1, and clears blk_cnt and err_cnt.
- Unsettled hdr_ok_i=0: go to SEARCH with stable_cnt=0. offset_o keeps its value.

LOCKED:
- Each hdr_dv_i: blk_cnt+1. A bad header (unsettled) also does err_cnt+1.
- When err_cnt reaches ERR_MAX:
  - Go to SEARCH; locked_o=0.
  - lock_loss_cnt_o+1, saturating at 255.
  - stable_cnt=0.
- When blk_cnt reaches WIN_BLK-1 on a dv cycle: blk_cnt=0, err_cnt=0.
- If the ERR_MAX-th error falls on the last block of a window, lock loss takes priority over the window clear.
- seek_offset_i is ignored while LOCKED. offset_o never changes outside SEARCH.

Reset values:
- state SEARCH, offset_o=0, offset_load_o=0, locked_o=0, lock_loss_cnt_o=0.
- All internal counters 0; the previous-sample register holds 7'h7F.

Reset asserted mid-operation returns all of the above to reset values on the next edge. No offset_load_o is emitted on reset exit.

## Timing

- Input sampled at edge N (hdr_dv_i=1) → resulting state_o, offset_o, offset_load_o, locked_o and lock_loss_cnt_o are visible after edge N (1-cycle latency).
- offset_load_o is high for exactly one cycle per load. Back-to-back dv cycles are supported with no bubbles.
- Minimum time from reset release to locked_o, with settle blocks counted as part of VERIFY: STABLE_CNT + SETTLE_BLK + LOCK_CNT dv cycles.
- Counter widths:
  - stable_cnt and good_cnt: 8 bits.
  - blk_cnt and err_cnt: ceil(log2(WIN_BLK+1)) bits.
  - All counters compare with equality to their parameter value.

## Test plan

- Clean lock: defaults, seek_offset_i=37 constant, hdr_ok_i=1 on every dv.
  - offset_load_o pulses once with offset_o=37 after the 8th dv.
  - locked_o rises after dv #42.
  - state_o goes 0→1→2.
- Unstable candidate: seek_offset_i alternates 10/11 for 20 dv, then holds 11.
  - No load during alternation.
  - Load with offset_o=11 on the 7th dv of the constant stretch.
- Out-of-range input: seek_offset_i=70 for 20 dv → stays in SEARCH, no load, stable count held at 0.
- VERIFY failure: after a load, 2 bad settle blocks then good headers, with one bad at good_cnt=5.
  - Settle blocks are ignored.
  - The bad header returns state_o to 0; offset_o is unchanged; lock_loss_cnt_o stays 0.
- Lock loss and window behaviour:
  - In LOCKED, 15 errors in window 1 then 15 in window 2 → stays locked.
  - 16 errors within one window → locked_o=0, lock_loss_cnt_o=1.
  - 16th error on block 63 of a window → lock loss occurs.
- Saturation and reset: force 300 lock losses.
  - lock_loss_cnt_o holds at 255.
  - rst_i pulsed while LOCKED → all outputs reach reset values the next cycle and offset_load_o stays 0.
